// File: rtl/boot_pkg.sv
// Shared types for the boot sequencer: FSM encoding, memory address widths,
// the data-memory write request carried into the port mux, and a saturating
// counter step used for the loader word counts.
package boot_pkg;

  localparam int IMEM_AW = 6;
  localparam int DMEM_AW = 5;
  localparam int XLEN    = 32;
  localparam int CNT_W   = 8;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    HOLD = 2'd1,
    RUN  = 2'd2,
    ERR  = 2'd3
  } boot_state_e;

  // One write request toward data memory (from the loader or from the core).
  typedef struct packed {
    logic               we;
    logic [DMEM_AW-1:0] addr;
    logic [XLEN-1:0]    wdata;
  } dmem_wr_t;

  // Count up by one when en is set, sticking at all-ones.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt,
                                               input logic             en);
    return (en && (cnt != {CNT_W{1'b1}})) ? cnt + 1'b1 : cnt;
  endfunction

endpackage

// File: rtl/boot_wport_mux.sv
// Registered 2:1 write-port mux. Source A is picked when sel=0, source B when
// sel=1; each source carries its own enable. Address/data only move on an
// actual write so the port lines stay quiet between writes.
module boot_wport_mux
  import boot_pkg::*;
(
  input  logic     sys_clk,
  input  logic     sys_arstn,
  input  logic     sel,
  input  dmem_wr_t src_a,
  input  dmem_wr_t src_b,
  output dmem_wr_t port
);

  dmem_wr_t pick;

  // Select the active source for this cycle.
  always_comb begin
    pick = src_a;
    if (sel) pick = src_b;
  end

  // One-cycle register stage toward the memory write port.
  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      port <= '0;
    end else begin
      port.we <= pick.we;
      if (pick.we) begin
        port.addr  <= pick.addr;
        port.wdata <= pick.wdata;
      end
    end
  end

endmodule

// File: rtl/boot_load_ctrl.sv
// Boot sequencer between the UART loader and the core. While loading it
// forwards loader writes to imem/dmem, counts words and folds them into an
// XOR checksum. A rising ld_start with the exact word counts starts a fixed
// hold period, after which the core is released and owns the dmem port.
// A wrong count parks the block in ERR until reset.
module boot_load_ctrl
  import boot_pkg::*;
#(
  parameter int INST_WORDS  = 64,
  parameter int DATA_WORDS  = 32,
  parameter int HOLD_CYCLES = 16
) (
  input  logic               sys_clk,
  input  logic               sys_arstn,
  input  logic               ld_inst_we,
  input  logic [IMEM_AW-1:0] ld_inst_addr,
  input  logic               ld_data_we,
  input  logic [DMEM_AW-1:0] ld_data_addr,
  input  logic [XLEN-1:0]    ld_wdata,
  input  logic               ld_start,
  input  logic               cpu_dmem_req,
  input  logic               cpu_dmem_we,
  input  logic [DMEM_AW-1:0] cpu_dmem_addr,
  input  logic [XLEN-1:0]    cpu_dmem_wdata,
  output logic               cpu_dmem_gnt,
  output logic               imem_we,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [XLEN-1:0]    imem_wdata,
  output logic               dmem_we,
  output logic [DMEM_AW-1:0] dmem_addr,
  output logic [XLEN-1:0]    dmem_wdata,
  output logic               cpu_run,
  output logic               boot_err,
  output logic [XLEN-1:0]    boot_csum
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]    HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] INST_REQ  = CNT_W'(INST_WORDS);
  localparam logic [CNT_W-1:0] DATA_REQ  = CNT_W'(DATA_WORDS);

  boot_state_e      state;
  logic             start_q;
  logic             start_rise;
  logic [CNT_W-1:0] inst_cnt;
  logic [CNT_W-1:0] data_cnt;
  logic [HW-1:0]    hold_cnt;
  logic             in_load;
  logic             in_run;
  logic             ld_any;

  dmem_wr_t dm_ld;
  dmem_wr_t dm_cpu;
  dmem_wr_t dm_port;

  assign in_load    = (state == LOAD);
  assign in_run     = (state == RUN);
  assign ld_any     = ld_inst_we | ld_data_we;
  assign start_rise = ld_start & ~start_q;

  // The core owns the dmem port exactly while running; tracks cpu_run.
  assign cpu_dmem_gnt = in_run;

  // Boot FSM with its counters, checksum and registered status outputs.
  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      state     <= LOAD;
      start_q   <= 1'b0;
      inst_cnt  <= '0;
      data_cnt  <= '0;
      hold_cnt  <= '0;
      cpu_run   <= 1'b0;
      boot_err  <= 1'b0;
      boot_csum <= '0;
    end else begin
      start_q <= ld_start;
      case (state)
        LOAD: begin
          inst_cnt  <= sat_inc(inst_cnt, ld_inst_we);
          data_cnt  <= sat_inc(data_cnt, ld_data_we);
          // Dual strobes fold the same word twice and cancel out.
          boot_csum <= boot_csum
                     ^ (ld_inst_we ? ld_wdata : '0)
                     ^ (ld_data_we ? ld_wdata : '0);
          if (start_rise) begin
            if ((inst_cnt == INST_REQ) && (data_cnt == DATA_REQ)) begin
              state    <= HOLD;
              hold_cnt <= '0;
            end else begin
              state    <= ERR;
              boot_err <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state   <= RUN;
            cpu_run <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        RUN: begin
          // A loader write after release means the image went out of sync.
          if (ld_any) boot_err <= 1'b1;
        end
        ERR: begin
          boot_err <= 1'b1;
          cpu_run  <= 1'b0;
        end
        default: begin
          state    <= ERR;
          boot_err <= 1'b1;
          cpu_run  <= 1'b0;
        end
      endcase
    end
  end

  // Loader-only register stage toward the instruction-memory write port.
  always_ff @(posedge sys_clk or negedge sys_arstn) begin
    if (!sys_arstn) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      imem_we <= in_load & ld_inst_we;
      if (in_load && ld_inst_we) begin
        imem_addr  <= ld_inst_addr;
        imem_wdata <= ld_wdata;
      end
    end
  end

  // Build the two dmem write sources; each is gated by the state owning the port.
  always_comb begin
    dm_ld.we     = in_load & ld_data_we;
    dm_ld.addr   = ld_data_addr;
    dm_ld.wdata  = ld_wdata;
    dm_cpu.we    = in_run & cpu_dmem_req & cpu_dmem_we;
    dm_cpu.addr  = cpu_dmem_addr;
    dm_cpu.wdata = cpu_dmem_wdata;
  end

  boot_wport_mux u_dmem_mux (
    .sys_clk   (sys_clk),
    .sys_arstn (sys_arstn),
    .sel       (in_run),
    .src_a     (dm_ld),
    .src_b     (dm_cpu),
    .port      (dm_port)
  );

  assign dmem_we    = dm_port.we;
  assign dmem_addr  = dm_port.addr;
  assign dmem_wdata = dm_port.wdata;

endmodule

// File: doc/boot_load_ctrl.md
# boot_load_ctrl

Boot sequencer and memory-port arbiter between the UART program loader and the RISC-V core. It owns the write ports of instruction memory (64 words) and data memory (32 words). During boot it forwards loader writes, verifies that exactly the expected number of words arrived, and holds the core in reset. It then releases the core after a fixed hold period and hands the data-memory port to the core.

## Interface
Parameters:
- INST_WORDS, 64: instruction words required before release.
- DATA_WORDS, 32: data words required before release.
- HOLD_CYCLES, 16: cycles from a good start to core release (≥1).

Ports:
- sys_clk  in  1  single clock; all logic on the rising edge.
- sys_arstn  in  1  reset, asynchronous, active-low.
- ld_inst_we  in  1  loader instruction-word strobe.
- ld_inst_addr  in  6  loader instruction address.
- ld_data_we  in  1  loader data-word strobe.
- ld_data_addr  in  5  loader data address.
- ld_wdata  in  32  loader word, shared by both strobes.
- ld_start  in  1  loader "image complete" level; the rising edge is used.
- cpu_dmem_req  in  1  core data-memory request.
- cpu_dmem_we  in  1  core write qualifier.
- cpu_dmem_addr  in  5  core data address.
- cpu_dmem_wdata  in  32  core write data.
- cpu_dmem_gnt  out  1  core owns the dmem port.
- imem_we, imem_addr[5:0], imem_wdata[31:0]  out  instruction-memory write port.
- dmem_we, dmem_addr[4:0], dmem_wdata[31:0]  out  data-memory write port.
- cpu_run  out  1  core reset release, active-high.
- boot_err  out  1  sticky boot failure.
- boot_csum  out  32  XOR of all accepted loader words.

## Operation
- States: LOAD (reset state), HOLD, RUN, ERR.
- LOAD:
  - Each ld_inst_we is forwarded to the imem port, inst_cnt increments, and boot_csum ^= ld_wdata.
  - ld_data_we is handled the same way, using the dmem port and data_cnt.
  - Both strobes in the same cycle: both writes are forwarded, both counters increment, and boot_csum ^= ld_wdata once per strobe (net zero).
  - Core requests are ignored and cpu_dmem_gnt is 0.
- Counters are 8-bit and saturate at 255.
- ld_start rising edge in LOAD:
  - inst_cnt==INST_WORDS and data_cnt==DATA_WORDS → HOLD.
  - Otherwise → ERR.
- HOLD: loader strobes are dropped. hold_cnt counts 0..HOLD_CYCLES-1, then → RUN.
- RUN:
  - cpu_run=1 and cpu_dmem_gnt=1.
  - A request with cpu_dmem_req & cpu_dmem_we is forwarded to the dmem port.
  - Loader strobes are dropped, and a late strobe sets boot_err (state stays RUN).
- ERR: boot_err=1, cpu_run=0, all write enables 0. The state is left only by reset.
- A ld_start rising edge outside LOAD is ignored.
- Reset at any time, including mid-load or mid-hold: immediately returns to LOAD. Counters, hold_cnt, boot_csum and all outputs are cleared, and the memories are untouched.

## Timing
- Reset values: imem_we=0, dmem_we=0, addresses and wdata 0, cpu_run=0, cpu_dmem_gnt=0, boot_err=0, boot_csum=0.
- The write ports are registered. A strobe in cycle N appears on *_we/addr/wdata in cycle N+1, for one cycle per strobe.
- ld_start edge detection uses a 1-cycle registered previous value. An edge sampled at cycle N gives state HOLD (or ERR) at N+1.
- cpu_run rises at N+1+HOLD_CYCLES.
- cpu_dmem_gnt is decoded combinationally from state==RUN, so it is coincident with cpu_run.
- Core writes have 1-cycle latency to dmem_we.
- boot_err is registered: high the cycle after the ERR entry or the late strobe.
- boot_csum updates the cycle after each accepted strobe.

## Structure
- Shared package boot_pkg holds:
  - the state encoding: LOAD=2'd0, HOLD=2'd1, RUN=2'd2, ERR=2'd3;
  - address width constants IMEM_AW=6 and DMEM_AW=5.
- One sub-module, boot_wport_mux, is natural: a registered 2:1 write-port mux with a select and per-source enables. It is instantiated for dmem; imem uses a loader-only register stage.

## Test plan
- Good boot: 64 inst strobes (data=addr) and 32 data strobes, then ld_start, with HOLD_CYCLES=16 → each write appears 1 cycle later with matching addr/data; cpu_run=1 exactly 17 cycles after the start edge; boot_err=0; boot_csum equals the XOR of all 96 words.
- Short image: 63 inst and 32 data strobes, then ld_start → ERR the next cycle; boot_err=1; cpu_run stays 0 for 100 cycles; a further ld_start has no effect.
- Simultaneous strobes: ld_inst_we and ld_data_we in the same cycle with ld_wdata=32'hA5A5_0001 → both ports written in the next cycle; both counters +1; boot_csum unchanged.
- Arbitration: in RUN, core write addr 5'd3, data 32'hDEAD_BEEF → dmem_we=1 next cycle with those values. A core request during LOAD → no dmem write and gnt=0.
- Late loader: in RUN, one ld_data_we → no dmem write, boot_err=1 next cycle, cpu_run stays 1.
- Reset mid-HOLD: assert sys_arstn=0 at hold_cnt=5 → all outputs 0 immediately; after release, a full good boot completes normally.
